// File: rtl/timer_arbiter_if.sv
// -----------------------------------------------------------------------------
// timer_arbiter_if
// Bundles the request/grant signals that connect the requesting FSMs to the
// shared countdown timer arbiter.
//
//   req       : per-requester request level (bit i = requester i)
//   dur       : flattened durations, requester i uses dur[i*CW +: CW]
//   abort     : cancels the countdown that is currently running
//   grant     : one-hot owner of the timer, zero when idle
//   busy      : high while a countdown or its done cycle is in progress
//   done      : one-cycle completion pulse to the owning requester
//   remaining : current countdown value, zero when idle
//
// The master modport is the requester side; the slave modport is the arbiter.
// -----------------------------------------------------------------------------
interface timer_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] dur;
  logic               abort;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [NREQ-1:0]    done;
  logic [CW-1:0]      remaining;

  modport master (
    output req, dur, abort,
    input  grant, busy, done, remaining
  );

  modport slave (
    input  req, dur, abort,
    output grant, busy, done, remaining
  );
endinterface

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
// Round-robin arbiter and sequencer for one shared down-counting timer.
// Each requester supplies a duration in ticks; the arbiter grants the timer to
// one requester at a time, runs the countdown and pulses that requester's done.
//
//   clk_250 : system clock, all state changes on its rising edge
//   rst     : synchronous, active-high reset
//   bus     : timer_arbiter_if.slave carrying req/dur/abort in and
//             grant/busy/done/remaining out (all outputs registered)
// -----------------------------------------------------------------------------
module timer_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input logic            clk_250,
  input logic            rst,
  timer_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic [CW-1:0]   remaining_q;

  logic            arbValid_d;
  logic [IW-1:0]   arbIdx_d;
  logic [CW-1:0]   durSel_d;
  logic [IW-1:0]   ptr_d;

  logic            hiFound;
  logic [IW-1:0]   hiIdx;
  logic [IW-1:0]   anyIdx;

  // Round-robin pick: the lowest requesting index at or above the pointer
  // wins; if none exists the search wraps and the lowest requesting index
  // overall wins. Scanning downward lets the last hit be the lowest one.
  always_comb begin
    arbValid_d = 1'b0;
    hiFound    = 1'b0;
    hiIdx      = '0;
    anyIdx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        arbValid_d = 1'b1;
        anyIdx     = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hiFound = 1'b1;
          hiIdx   = IW'(i);
        end
      end
    end
    arbIdx_d = hiFound ? hiIdx : anyIdx;
  end

  // Duration of the requester that would win arbitration this cycle.
  always_comb begin
    durSel_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arbIdx_d == IW'(i)) begin
        durSel_d = bus.dur[i*CW +: CW];
      end
    end
  end

  // After a run ends (done or abort) the owner becomes lowest priority.
  always_comb begin
    ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
  end

  // Single sequencer: IDLE arbitrates and latches the duration, RUN counts
  // down to zero (abort releases immediately), DONE holds grant for the one
  // cycle of the done pulse. Reset overrides everything, including a run.
  always_ff @(posedge clk_250) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= '0;
          if (arbValid_d) begin
            owner_q     <= arbIdx_d;
            grant_q     <= {{(NREQ-1){1'b0}}, 1'b1} << arbIdx_d;
            remaining_q <= durSel_d;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end else begin
            grant_q     <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            grant_q     <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
          end else if (remaining_q != '0) begin
            remaining_q <= remaining_q - CW'(1);
          end else begin
            done_q  <= grant_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q      <= '0;
          grant_q     <= '0;
          busy_q      <= 1'b0;
          remaining_q <= '0;
          ptr_q       <= ptr_d;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timer_arbiter
// Directed bench for timer_arbiter. A behavioural model tracks the owner,
// the cycles elapsed since its grant and the round-robin pointer, and every
// cycle the DUT outputs are compared against it. Directed scenarios add
// hand-computed literal expectations on top.
// -----------------------------------------------------------------------------
module tb_timer_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic clk_250 = 1'b0;
  logic rst     = 1'b1;

  int checks = 0;
  int errors = 0;

  timer_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

  timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk_250 (clk_250),
    .rst     (rst),
    .bus     (bus)
  );

  always #2 clk_250 = ~clk_250;

  // Model state: owner index (-1 = nobody), latched duration, cycles since
  // grant, and the index that currently has top priority.
  int mOwner   = -1;
  int mDur     = 0;
  int mElapsed = 0;
  int mPtr     = 0;
  int cand;
  logic [NREQ-1:0] expGrant;
  logic [NREQ-1:0] expDone;
  logic            expBusy;
  logic [CW-1:0]   expRem;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] reqVal, input logic abortVal);
    bus.req   = reqVal;
    bus.abort = abortVal;
  endtask

  task automatic setDur(input int idx, input logic [CW-1:0] val);
    bus.dur[idx*CW +: CW] = val;
  endtask

  function automatic int durOf(input int idx);
    return int'(CW'(bus.dur >> (idx*CW)));
  endfunction

  // Model step on each rising edge using the inputs held stable since the
  // previous falling edge, then compare the DUT outputs shortly after.
  // A grant lasts D+1 cycles of countdown plus one done cycle.
  always @(posedge clk_250) begin
    if (rst) begin
      mOwner = -1;
      mPtr   = 0;
    end else if (mOwner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (mPtr + k) % NREQ;
        if (mOwner < 0 && ((bus.req >> cand) & 1) != 0) begin
          mOwner   = cand;
          mDur     = durOf(cand);
          mElapsed = 0;
        end
      end
    end else if (mElapsed == mDur + 1) begin
      mPtr   = (mOwner + 1) % NREQ;
      mOwner = -1;
    end else if (bus.abort) begin
      mPtr   = (mOwner + 1) % NREQ;
      mOwner = -1;
    end else begin
      mElapsed++;
    end
    #1;
    if (mOwner < 0) begin
      expGrant = '0;
      expDone  = '0;
      expBusy  = 1'b0;
      expRem   = '0;
    end else begin
      expGrant = NREQ'(1) << mOwner;
      expBusy  = 1'b1;
      expRem   = (mDur > mElapsed) ? CW'(mDur - mElapsed) : '0;
      expDone  = (mElapsed == mDur + 1) ? expGrant : '0;
    end
    checkOutput("model.grant", 32'(bus.grant), 32'(expGrant));
    checkOutput("model.busy", 32'(bus.busy), 32'(expBusy));
    checkOutput("model.done", 32'(bus.done), 32'(expDone));
    checkOutput("model.remaining", 32'(bus.remaining), 32'(expRem));
  end

  task automatic waitGrant(input string name, input logic [NREQ-1:0] mask,
                           input int budget);
    int found;
    found = 0;
    for (int c = 0; c < budget && found == 0; c++) begin
      @(negedge clk_250);
      if (bus.grant == mask) found = 1;
    end
    checkOutput(name, found, 1);
  endtask

  task automatic waitRemaining(input string name, input logic [CW-1:0] val,
                               input int budget);
    int found;
    found = 0;
    for (int c = 0; c < budget && found == 0; c++) begin
      @(negedge clk_250);
      if (bus.busy && bus.remaining == val) found = 1;
    end
    checkOutput(name, found, 1);
  endtask

  logic [NREQ-1:0] rrSeq [5];
  logic [NREQ-1:0] rrExp [5];
  int doneCnt [NREQ];
  int nGrants;
  int idleRun;
  logic [NREQ-1:0] prevGrant;
  int latency;

  initial begin
    rrExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.dur = '0;
    applyStimulus('0, 1'b0);
    repeat (3) @(negedge clk_250);
    checkOutput("reset.grant", 32'(bus.grant), 0);
    checkOutput("reset.busy", 32'(bus.busy), 0);
    rst = 1'b0;

    // Single request, duration 5
    setDur(1, 8'd5);
    applyStimulus(4'b0010, 1'b0);
    waitGrant("t1.grant", 4'b0010, 4);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("t1.rem5", 32'(bus.remaining), 5);
    for (int v = 4; v >= 0; v--) begin
      @(negedge clk_250);
      checkOutput("t1.remSeq", 32'(bus.remaining), v);
      checkOutput("t1.noDone", 32'(bus.done), 0);
    end
    @(negedge clk_250);
    checkOutput("t1.done", 32'(bus.done), 32'h2);
    @(negedge clk_250);
    checkOutput("t1.idleGrant", 32'(bus.grant), 0);
    checkOutput("t1.idleBusy", 32'(bus.busy), 0);

    // Zero duration
    setDur(0, 8'd0);
    applyStimulus(4'b0001, 1'b0);
    waitGrant("t2.grant", 4'b0001, 4);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("t2.rem0", 32'(bus.remaining), 0);
    @(negedge clk_250);
    checkOutput("t2.done", 32'(bus.done), 32'h1);
    @(negedge clk_250);
    checkOutput("t2.idle", 32'(bus.grant), 0);

    // Round robin with every request held, pointer restarted by reset
    @(negedge clk_250);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) setDur(i, 8'd2);
    applyStimulus(4'b1111, 1'b0);
    @(negedge clk_250);
    rst = 1'b0;
    nGrants = 0;
    idleRun = 0;
    prevGrant = '0;
    for (int i = 0; i < NREQ; i++) doneCnt[i] = 0;
    for (int c = 0; c < 60 && nGrants < 5; c++) begin
      @(negedge clk_250);
      for (int i = 0; i < NREQ; i++) doneCnt[i] += int'((bus.done >> i) & 1);
      if (bus.grant != 0 && prevGrant == 0) begin
        rrSeq[nGrants] = bus.grant;
        if (nGrants > 0) checkOutput("t3.idleGap", idleRun, 1);
        nGrants++;
      end
      if (bus.grant == 0) idleRun++;
      else idleRun = 0;
      prevGrant = bus.grant;
    end
    checkOutput("t3.count", nGrants, 5);
    for (int k = 0; k < 5; k++) checkOutput("t3.order", 32'(rrSeq[k]), 32'(rrExp[k]));
    for (int i = 0; i < NREQ; i++) checkOutput("t3.doneCnt", doneCnt[i], 1);
    applyStimulus(4'b0000, 1'b0);
    repeat (8) @(negedge clk_250);

    // Abort at remaining 6; pointer moves past requester 2 and wraps
    setDur(2, 8'd10);
    applyStimulus(4'b0100, 1'b0);
    waitGrant("t4.grant", 4'b0100, 4);
    waitRemaining("t4.rem6", 8'd6, 12);
    applyStimulus(4'b0101, 1'b1);
    @(negedge clk_250);
    applyStimulus(4'b0101, 1'b0);
    checkOutput("t4.abGrant", 32'(bus.grant), 0);
    checkOutput("t4.abRem", 32'(bus.remaining), 0);
    checkOutput("t4.abDone", 32'(bus.done), 0);
    @(negedge clk_250);
    checkOutput("t4.next", 32'(bus.grant), 32'h1);
    applyStimulus(4'b0000, 1'b0);
    repeat (8) @(negedge clk_250);

    // Reset in the middle of a run
    setDur(1, 8'd8);
    setDur(3, 8'd1);
    applyStimulus(4'b0010, 1'b0);
    waitGrant("t5.grant", 4'b0010, 4);
    waitRemaining("t5.rem4", 8'd4, 10);
    rst = 1'b1;
    applyStimulus(4'b1000, 1'b0);
    @(negedge clk_250);
    rst = 1'b0;
    checkOutput("t5.rstGrant", 32'(bus.grant), 0);
    checkOutput("t5.rstBusy", 32'(bus.busy), 0);
    checkOutput("t5.rstRem", 32'(bus.remaining), 0);
    checkOutput("t5.rstDone", 32'(bus.done), 0);
    @(negedge clk_250);
    checkOutput("t5.after", 32'(bus.grant), 32'h8);
    applyStimulus(4'b0000, 1'b0);
    repeat (6) @(negedge clk_250);

    // Duration and request changes during a run are ignored
    setDur(0, 8'd4);
    applyStimulus(4'b0001, 1'b0);
    waitGrant("t6.grant", 4'b0001, 4);
    setDur(0, 8'd200);
    applyStimulus(4'b0000, 1'b0);
    latency = 0;
    for (int c = 1; c <= 20 && latency == 0; c++) begin
      @(negedge clk_250);
      if (bus.done == 4'b0001) latency = c;
    end
    checkOutput("t6.latency", latency, 5);
    repeat (4) @(negedge clk_250);
    checkOutput("t6.idle", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared down-counting timer, clocked by clk_250.
- Up to NREQ requesters each supply a duration in ticks. The block grants the timer to one requester at a time, loads and runs the countdown, then pulses that requester's done line.
- Sits between game/control FSMs and the single timer resource, replacing per-FSM timer instances.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 8, countdown width in bits; durations 0..2^CW-1 ticks

Ports:
clk_250  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request level; bit i = requester i
dur  in  NREQ*CW  flattened durations; requester i uses bits [i*CW +: CW]
abort  in  1  cancels the running countdown
grant  out  NREQ  one-hot owner of the timer; all-zero when idle
busy  out  1  high while state is RUN or DONE
done  out  NREQ  one-cycle completion pulse to the owning requester
remaining  out  CW  current countdown value; 0 when idle

Behaviour:
- Reset, synchronous on rst=1:
  - grant=0, done=0, busy=0, remaining=0, state=IDLE.
  - Priority pointer=0, so requester 0 has highest priority on the first arbitration.
  - rst overrides every other input, including mid-RUN; no done pulse is issued for the cancelled run.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req≠0, select the first set bit searching upward from the pointer index, wrapping modulo NREQ.
  - Next edge: grant=onehot(sel), remaining=dur[sel], busy=1, state=RUN.
  - The dur value is sampled on the arbitration edge only; later changes to dur are ignored.
  - If req=0, stay in IDLE with all outputs at their reset values.
- RUN:
  - If abort=1: next edge grant=0, remaining=0, busy=0, no done pulse, pointer=sel+1 mod NREQ, state=IDLE.
  - Otherwise, if remaining>0: remaining decrements by 1 each edge.
  - Otherwise, when remaining=0: next edge state=DONE.
  - remaining saturates at 0 and never wraps.
  - req changes during RUN are ignored, including the owner dropping its req; grant is held until DONE or abort.
- DONE, exactly one cycle:
  - done[sel]=1 and grant still asserted.
  - Next edge: done=0, grant=0, busy=0, pointer=sel+1 mod NREQ, state=IDLE.
  - abort during DONE is ignored.
- Latency:
  - grant rises 1 cycle after req is sampled in IDLE.
  - done pulses D+1 cycles after grant rises, where D=dur[sel]. For D=0, done is the cycle right after grant.
  - After done, at least one IDLE cycle occurs before the next grant, so back-to-back grants are separated by one idle cycle.
- Fairness: a requester that holds req after its done is lowest priority in the next arbitration. With all requests held, the grant order is 0,1,…,NREQ-1,0,…
- Invariants:
  - grant is one-hot or zero.
  - done is nonzero only in DONE, and done ⊆ grant.
  - busy = (grant≠0).

Test Plan:
- Reset then single request: req=0010, dur[1]=5 -> grant=0010 one cycle later; remaining 5,4,3,2,1,0; done=0010 for one cycle 6 cycles after grant; then grant=0, busy=0.
- Zero duration: req=0001, dur[0]=0 -> grant=0001, remaining=0, done=0001 on the next cycle, then idle.
- Round-robin: req=1111 held, all dur=2 -> grant sequence 0001,0010,0100,1000,0001; each owner sees exactly one done pulse; one idle cycle between grants.
- Abort: req=0100, dur[2]=10, abort pulsed when remaining=6 -> next cycle grant=0, remaining=0, no done; with req=0101 held, next grant=0001 (pointer advanced to 3, wraps to 0).
- Mid-run reset: during RUN with remaining=4, assert rst for 1 cycle -> all outputs 0 next edge, no done; with req=1000 held afterwards, grant=1000 on the cycle after rst deasserts (pointer reset to 0, search finds 3).
- Input changes ignored: during RUN, change dur[owner] and drop req[owner] -> countdown continues from the latched value and done still pulses on schedule.
